prio_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 20 ++
 rtl/prio_pick.sv | 52 +++++
 rtl/prio_arbiter.sv | 88 ++++++++
 tb/tb_prio_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the priority arbiter and its combinational picker.
// The onehot helper is sized to the largest legal request count; callers truncate.
package arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    localparam int   MAX_N      = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
        logic [MAX_N-1:0] one;
        one = {{(MAX_N-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational winner selection: fixed highest-index priority or a round-robin
// scan upward from base. mask_en removes mask_idx from consideration.
module prio_pick
    import arb_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    input  logic [W-1:0] mask_idx,
    input  logic         mask_en,
    input  logic         mode,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [N-1:0] eligible;
    int           pos;

    always_comb begin
        eligible = req;
        pos      = 0;
        idx      = '0;
        found    = 1'b0;
        if (mask_en) begin
            eligible[mask_idx] = 1'b0;
        end
        if (mode == MODE_FIXED) begin
            // Ascending scan, so the last hit is the highest set index.
            for (int i = 0; i < N; i++) begin
                if (eligible[i]) begin
                    idx   = W'(i);
                    found = 1'b1;
                end
            end
        end else begin
            // Descending offset scan, so the last hit is the nearest to base.
            for (int k = N - 1; k >= 0; k--) begin
                pos = int'(base) + k;
                if (pos >= N) begin
                    pos = pos - N;
                end
                if (eligible[pos]) begin
                    idx   = W'(pos);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter: holds one grant until the consumer accepts it and
// reloads back-to-back on the accepting cycle when another requester is pending.
module prio_arbiter
    import arb_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] req,
    input  logic         gnt_ready,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] rr_ptr
);

    // Handshake: a grant transfers on a cycle where gnt_valid && gnt_ready; while
    // gnt_ready is low the grant outputs stay frozen whatever req/en/mode do.
    state_t       state;
    state_t       state_next;
    logic [W-1:0] pick_idx;
    logic         pick_found;
    logic [N-1:0] pick_oh;
    logic         handshake;
    logic         load;

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req      (req),
        .base     (rr_ptr),
        .mask_idx (gnt_idx),
        .mask_en  (state == ST_GRANT),
        .mode     (mode),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (load) state_next = ST_GRANT;
            ST_GRANT: if (handshake && !load) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        handshake = (state == ST_GRANT) && gnt_ready;
        load      = ((state == ST_IDLE) || handshake) && en && pick_found;
        pick_oh   = N'(onehot(int'(pick_idx)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            rr_ptr     <= '0;
        end else begin
            // The pointer advances past every accepted grant, even in fixed mode.
            if (handshake) begin
                rr_ptr <= (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (load) begin
                gnt_idx    <= pick_idx;
                gnt_onehot <= pick_oh;
            end else if (handshake) begin
                gnt_onehot <= '0;
            end
        end
    end

    assign gnt_valid = (state == ST_GRANT);

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter (N=8): each step queues its expected outputs,
// clocks once, then pops and compares them against the registered outputs.
module tb_prio_arbiter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic       gnt_ready;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_onehot;
    logic [2:0] rr_ptr;

    logic [14:0] exp_q[$];
    int          n_total;
    int          n_pass;

    prio_arbiter #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .req        (req),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .rr_ptr     (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the edge,
    // then pop and compare once the edge has passed.
    task automatic step(input string tag, input logic r, input logic e, input logic m,
                        input logic [7:0] rq, input logic rdy,
                        input logic ev, input logic [2:0] ei, input logic [2:0] er);
        logic [7:0]  eoh;
        logic [14:0] item;
        rst       = r;
        en        = e;
        mode      = m;
        req       = rq;
        gnt_ready = rdy;
        eoh = ev ? (8'h01 << ei) : 8'h00;
        exp_q.push_back({ev, ei, eoh, er});
        @(posedge clk);
        #1;
        item = exp_q.pop_front();
        chk({tag, ".valid"},  32'(gnt_valid),  32'(item[14]));
        chk({tag, ".idx"},    32'(gnt_idx),    32'(item[13:11]));
        chk({tag, ".onehot"}, 32'(gnt_onehot), 32'(item[10:3]));
        chk({tag, ".rr_ptr"}, 32'(rr_ptr),     32'(item[2:0]));
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b1;
        en        = 1'b1;
        mode      = 1'b0;
        req       = 8'hFF;
        gnt_ready = 1'b0;

        // Reset with every line requesting, then the first grant one cycle later.
        step("reset_a",    1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 3'd0);
        step("reset_b",    1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 3'd0);
        step("first_gnt",  1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 3'd7, 3'd0);

        // Fixed priority: highest set index wins, back-to-back on handshake.
        step("fixed_6",    1'b0, 1'b1, 1'b0, 8'b0100_0110, 1'b1, 1'b1, 3'd6, 3'd0);
        step("fixed_2",    1'b0, 1'b1, 1'b0, 8'b0000_0110, 1'b1, 1'b1, 3'd2, 3'd7);
        step("load_3",     1'b0, 1'b1, 1'b0, 8'h08,        1'b1, 1'b1, 3'd3, 3'd3);

        // Sticky hold while the request drops and en/mode wiggle.
        for (int i = 0; i < 5; i++) begin
            step("hold", 1'b0, (i == 2) ? 1'b0 : 1'b1, (i == 3) ? 1'b1 : 1'b0,
                 8'h00, 1'b0, 1'b1, 3'd3, 3'd3);
        end
        step("release",    1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 3'd4);
        step("idle_empty", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 3'd4);

        // Reset wins over a simultaneous handshake-eligible cycle; then round-robin.
        step("rst_rr",     1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 3'd0);
        for (int k = 0; k < 10; k++) begin
            step("rr_seq", 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 3'(k % 8), 3'(k % 8));
        end

        // Lone requester: re-grant alternates with a one-cycle bubble.
        step("single_4",   1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 3'd4, 3'd2);
        for (int j = 0; j < 4; j++) begin
            step("single_alt", 1'b0, 1'b1, 1'b1, 8'h10, 1'b1, (j % 2) == 1, 3'd4, 3'd5);
        end

        // en=0 does not abort a held grant but blocks new ones.
        step("en0_hold",    1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 3'd4, 3'd5);
        step("en0_deliver", 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 3'd4, 3'd5);
        step("en0_idle_a",  1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 3'd4, 3'd5);
        step("en0_idle_b",  1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 3'd4, 3'd5);
        step("regrant",     1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 3'd5);

        // Reset in GRANT discards the grant without a handshake.
        step("rst_mid",     1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 3'd0, 3'd0);
        step("post_rst",    1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 3'd0, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
